irq_controller: RTL and testbench



---
 rtl/irq_controller_if.sv | 28 ++
 rtl/irq_controller.sv | 143 ++++++++++++++
 tb/tb_irq_controller.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/irq_controller_if.sv
// Trap request/handshake bundle between the interrupt controller (slave)
// and the CPU/control-register side (master).
interface irq_controller_if #(
    parameter int NSRC  = 8,
    parameter int TRAPW = 4
);
    logic [NSRC-1:0]  src_in;
    logic             ien;
    logic             mask_we;
    logic [NSRC-1:0]  mask_in;
    logic [NSRC-1:0]  mask_out;
    logic             irq;
    logic             fault;
    logic [TRAPW-1:0] trapnr;
    logic             ack;
    logic             eoi;
    logic             in_service;

    modport slave (
        input  src_in, ien, mask_we, mask_in, ack, eoi,
        output mask_out, irq, fault, trapnr, in_service
    );

    modport master (
        output src_in, ien, mask_we, mask_in, ack, eoi,
        input  mask_out, irq, fault, trapnr, in_service
    );
endinterface

// File: rtl/irq_controller.sv
// Interrupt/fault controller: latches NSRC request lines, picks the lowest
// eligible index and tracks it through the core's ack / eoi handshake.
module irq_controller #(
    parameter int              NSRC      = 8,
    parameter int              NFAULT    = 1,
    parameter logic [NSRC-1:0] EDGE_MASK = '0,
    parameter logic [NSRC-1:0] MASK_INIT = '0,
    parameter int              TRAP_BASE = 1,
    parameter int              TRAPW     = 4
) (
    input  logic           clk,
    input  logic           reset,
    irq_controller_if.slave bus
);
    localparam int IDXW = (NSRC > 1) ? $clog2(NSRC) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t            state_reg, state_next;
    logic [NSRC-1:0]   src_q_reg;
    logic [NSRC-1:0]   mask_reg;
    logic              irq_reg, irq_next;
    logic              fault_reg, fault_next;
    logic [TRAPW-1:0]  trapnr_reg, trapnr_next;

    logic [NSRC-1:0]   pending;
    logic [NSRC-1:0]   eligible;
    logic              any_eligible;
    logic [IDXW-1:0]   win_idx;
    logic              win_is_fault;
    logic              ack_take;

    assign ack_take = (state_reg == REQ) && bus.ack;

    // Per-channel pending source. The trap number in flight identifies the
    // winner, so an accepted ack clears the matching edge latch.
    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_chan
            if (EDGE_MASK[gi]) begin : g_edge
                logic pend_reg;
                logic rise;
                logic clr;
                assign rise = bus.src_in[gi] & ~src_q_reg[gi];
                assign clr  = ack_take && (trapnr_reg == TRAPW'(TRAP_BASE + gi));
                always_ff @(posedge clk) begin
                    if (reset) begin
                        pend_reg <= 1'b0;
                    end else begin
                        // a fresh edge on the same cycle as its ack survives
                        pend_reg <= rise | (pend_reg & ~clr);
                    end
                end
                assign pending[gi] = pend_reg;
            end else begin : g_level
                assign pending[gi] = src_q_reg[gi];
            end

            if (gi < NFAULT) begin : g_fault
                assign eligible[gi] = pending[gi];
            end else begin : g_irq
                assign eligible[gi] = pending[gi] & mask_reg[gi] & bus.ien;
            end
        end
    endgenerate

    assign any_eligible = |eligible;

    always_comb begin
        win_idx = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) begin
                win_idx = IDXW'(i);
            end
        end
    end

    assign win_is_fault = (int'(win_idx) < NFAULT);

    // State register and all registered datapath state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg  <= IDLE;
            src_q_reg  <= '0;
            mask_reg   <= MASK_INIT;
            irq_reg    <= 1'b0;
            fault_reg  <= 1'b0;
            trapnr_reg <= '0;
        end else begin
            state_reg  <= state_next;
            src_q_reg  <= bus.src_in;
            irq_reg    <= irq_next;
            fault_reg  <= fault_next;
            trapnr_reg <= trapnr_next;
            if (bus.mask_we) begin
                mask_reg <= bus.mask_in;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (any_eligible) state_next = REQ;
            REQ:     if (ack_take)     state_next = SERVICE;
            SERVICE: if (bus.eoi)      state_next = IDLE;
            default:                   state_next = IDLE;
        endcase
    end

    // Output update: the winner is captured once in IDLE and never retracted.
    always_comb begin
        irq_next    = irq_reg;
        fault_next  = fault_reg;
        trapnr_next = trapnr_reg;
        case (state_reg)
            IDLE: begin
                if (any_eligible) begin
                    trapnr_next = TRAPW'(TRAP_BASE) + TRAPW'(win_idx);
                    fault_next  = win_is_fault;
                    irq_next    = ~win_is_fault;
                end
            end
            REQ: begin
                if (ack_take) begin
                    irq_next   = 1'b0;
                    fault_next = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.mask_out   = mask_reg;
    assign bus.irq        = irq_reg;
    assign bus.fault      = fault_reg;
    assign bus.trapnr     = trapnr_reg;
    assign bus.in_service = (state_reg == SERVICE);
endmodule

// File: tb/tb_irq_controller.sv
// Randomised and directed check of irq_controller against a trap-level
// reference model (which channel is in flight and what phase it is in).
module tb_irq_controller;
    localparam int         NSRC      = 8;
    localparam int         NFAULT    = 1;
    localparam logic [7:0] EDGE_MASK = 8'h06;
    localparam logic [7:0] MASK_INIT = 8'h3C;
    localparam int         TRAP_BASE = 1;
    localparam int         TRAPW     = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    irq_controller_if #(.NSRC(NSRC), .TRAPW(TRAPW)) bus ();

    irq_controller #(
        .NSRC(NSRC), .NFAULT(NFAULT), .EDGE_MASK(EDGE_MASK),
        .MASK_INIT(MASK_INIT), .TRAP_BASE(TRAP_BASE), .TRAPW(TRAPW)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus.slave)
    );

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: phase 0 = nothing issued, 1 = trap offered, 2 = in service.
    bit [7:0] m_prev, m_edge_pend, m_mask, m_clear;
    bit       m_irq, m_fault, m_valid;
    bit [3:0] m_trap;
    int       m_phase, m_cur, m_win;
    bit       m_p, m_ok;

    initial m_valid = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_prev = '0; m_edge_pend = '0; m_mask = MASK_INIT;
            m_irq = 0; m_fault = 0; m_trap = '0; m_phase = 0; m_cur = 0;
            m_valid = 1'b1;
        end else begin
            m_win = -1;
            for (int i = 0; i < NSRC; i++) begin
                m_p  = EDGE_MASK[i] ? m_edge_pend[i] : m_prev[i];
                m_ok = (i < NFAULT) || (m_mask[i] && bus.ien);
                if (m_win < 0 && m_p && m_ok) m_win = i;
            end
            m_clear = '0;
            if (m_phase == 0) begin
                if (m_win >= 0) begin
                    m_cur   = m_win;
                    m_trap  = 4'(TRAP_BASE + m_win);
                    m_fault = (m_win < NFAULT);
                    m_irq   = !m_fault;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                if (bus.ack) begin
                    m_irq = 0; m_fault = 0; m_clear[m_cur] = 1'b1; m_phase = 2;
                end
            end else begin
                if (bus.eoi) m_phase = 0;
            end
            m_edge_pend = ((bus.src_in & ~m_prev) | (m_edge_pend & ~m_clear)) & EDGE_MASK;
            m_prev = bus.src_in;
            if (bus.mask_we) m_mask = bus.mask_in;
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            tests_run++;
            if ({bus.irq, bus.fault, bus.trapnr, bus.in_service, bus.mask_out} !==
                {m_irq, m_fault, m_trap, (m_phase == 2), m_mask}) begin
                tests_failed++;
                $display("FAIL model t=%0t irq/fault/trapnr/insvc/mask got %b/%b/%0d/%b/%h exp %b/%b/%0d/%b/%h",
                         $time, bus.irq, bus.fault, bus.trapnr, bus.in_service, bus.mask_out,
                         m_irq, m_fault, m_trap, (m_phase == 2), m_mask);
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input int act, input int exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s got %0d exp %0d", name, act, exp);
        end else begin
            $display("[TB] %s = %0d ok", name, act);
        end
    endtask

    task automatic write_mask(input logic [7:0] m);
        bus.mask_we = 1'b1; bus.mask_in = m;
        tick();
        bus.mask_we = 1'b0;
    endtask

    task automatic ack_eoi();
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        tick();
    endtask

    initial begin
        reset = 1'b1;
        bus.src_in = '0; bus.ien = 1'b0; bus.mask_we = 1'b0; bus.mask_in = '0;
        bus.ack = 1'b0; bus.eoi = 1'b0;
        tick(2);
        reset = 1'b0;
        check("reset_irq", bus.irq, 0);
        check("reset_trapnr", bus.trapnr, 0);
        check("reset_mask", bus.mask_out, 8'h3C);

        // Level source 3, re-request after eoi while still high.
        bus.ien = 1'b1;
        write_mask(8'hFF);
        bus.src_in = 8'h08;
        tick(2);
        check("lvl3_irq", bus.irq, 1);
        check("lvl3_trapnr", bus.trapnr, 4);
        bus.ack = 1'b1; tick(); bus.ack = 1'b0;
        check("lvl3_ack_irq", bus.irq, 0);
        check("lvl3_in_service", bus.in_service, 1);
        bus.eoi = 1'b1; tick(); bus.eoi = 1'b0;
        tick();
        check("lvl3_rereq_irq", bus.irq, 1);
        bus.src_in = '0;
        ack_eoi();

        // Fault ignores ien and mask.
        bus.ien = 1'b0;
        write_mask(8'h00);
        bus.src_in = 8'h01;
        tick(2);
        check("fault_fault", bus.fault, 1);
        check("fault_irq", bus.irq, 0);
        check("fault_trapnr", bus.trapnr, 1);
        bus.src_in = '0;
        ack_eoi();

        // Edge channel 2 single pulse.
        bus.ien = 1'b1;
        write_mask(8'hFF);
        bus.src_in = 8'h04; tick(); bus.src_in = '0;
        tick();
        check("edge2_trapnr", bus.trapnr, 3);
        ack_eoi();

        // Reset while a trap is offered forgets the pending edge.
        bus.src_in = 8'h04; tick(); bus.src_in = '0;
        tick();
        reset = 1'b1; tick(); reset = 1'b0;
        check("rst_req_irq", bus.irq, 0);
        check("rst_req_trapnr", bus.trapnr, 0);
        check("rst_req_mask", bus.mask_out, 8'h3C);
        tick(3);
        check("rst_forgot_irq", bus.irq, 0);

        // Randomised traffic checked by the model every cycle.
        for (int c = 0; c < 4000; c++) begin
            reset       = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 7) == 0) bus.src_in = 8'($urandom & $urandom);
            bus.ien     = ($urandom_range(0, 7) != 0);
            bus.mask_we = ($urandom_range(0, 15) == 0);
            bus.mask_in = 8'($urandom);
            bus.ack     = ($urandom_range(0, 2) == 0);
            bus.eoi     = ($urandom_range(0, 2) == 0);
            tick();
        end
        reset = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
